// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the RAM stream reader: FSM encodings, return-path tag, address wrap helper.
package ram_stream_reader_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

    // Increment modulo md; md need not be a power of two.
    function automatic logic [31:0] adr_wrap_inc(input logic [31:0] adr, input int unsigned md);
        return (adr == 32'(md - 1)) ? 32'd0 : adr + 32'd1;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; D must be a power of two, head visible while not empty.
module sync_fifo_fwft #(
    parameter int unsigned W = 8,
    parameter int unsigned D = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [W-1:0]         wdata,
    input  logic                 pop,
    output logic [W-1:0]         rdata,
    output logic [$clog2(D):0]   count,
    output logic                 empty,
    output logic                 full
);

    localparam int unsigned PW = $clog2(D);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem_q [D];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(D));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(D); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Streams LEN consecutive RAM words from a base address as a valid/ready stream,
// hiding the RAM read latency behind a credit-controlled skid FIFO.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int unsigned READ_REGISTERED = 1,
    parameter int unsigned DW              = 8,
    parameter int unsigned MD              = 1024,
    parameter int unsigned AW              = $clog2(MD),
    parameter int unsigned FD              = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_adr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          rd,
    output logic [AW-1:0] adr_r,
    input  logic [DW-1:0] dat_r,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last
);

    localparam int unsigned RL = 1 + READ_REGISTERED;
    localparam int unsigned CW = $clog2(FD) + 1;
    localparam int unsigned KW = CW + 1;
    localparam int unsigned LW = AW + 1;

    logic [1:0]    state_q, state_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [AW-1:0] adr_d;
    logic          rd_d;
    logic          rd_last_q, rd_last_d;
    logic          busy_d;
    logic          done_d;

    tag_t          tag_q [RL];
    logic [CW-1:0] inflight_q;

    logic          fifo_push;
    logic          fifo_pop;
    logic [DW:0]   fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic [KW-1:0] credit;
    logic          can_issue;
    logic          drain_done;

    assign fifo_push = tag_q[RL-1].valid;
    assign m_valid   = !fifo_empty;
    assign fifo_pop  = m_valid && m_ready;
    assign m_last    = fifo_head[DW];
    assign m_data    = fifo_head[DW-1:0];

    // Slots already promised: buffered words, reads in the RAM pipe and the read on rd now, less this pop.
    assign credit    = KW'(fifo_count) + KW'(inflight_q) + KW'(rd) - KW'(fifo_pop);
    assign can_issue = (credit < KW'(FD));

    // Last word leaves this cycle with nothing else pending, so done lands right after the handshake.
    assign drain_done = (inflight_q == '0) && !rd &&
                        ((fifo_count == '0) || ((fifo_count == CW'(1)) && fifo_pop));

    sync_fifo_fwft #(
        .W (DW + 1),
        .D (FD)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata ({tag_q[RL-1].last, dat_r}),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        adr_d     = rd ? AW'(adr_wrap_inc(32'(adr_r), MD)) : adr_r;
        rd_d      = 1'b0;
        rd_last_d = 1'b0;
        busy_d    = busy;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d   = S_RUN;
                        busy_d    = 1'b1;
                        rd_d      = 1'b1;
                        rd_last_d = (len == LW'(1));
                        adr_d     = base_adr;
                        rem_d     = len - LW'(1);
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (rem_q == '0) begin
                    state_d = S_DRAIN;
                end else if (can_issue) begin
                    rd_d      = 1'b1;
                    rd_last_d = (rem_q == LW'(1));
                    rem_d     = rem_q - LW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_done) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            adr_r     <= '0;
            rd        <= 1'b0;
            rd_last_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            adr_r     <= adr_d;
            rd        <= rd_d;
            rd_last_q <= rd_last_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Return-path tags mirror the RAM read pipeline; the exiting tag qualifies dat_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RL); i++) begin
                tag_q[i] <= '0;
            end
            inflight_q <= '0;
        end else begin
            tag_q[0] <= tag_t'{valid: rd, last: rd_last_q};
            for (int i = 1; i < int'(RL); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            inflight_q <= inflight_q + CW'(rd) - CW'(tag_q[RL-1].valid);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: both read-latency variants side by side, each fed by its own RAM model.
module tb_ram_stream_reader;

    localparam int MD = 1024;
    localparam int FD = 4;
    localparam int QN = 4096;
    localparam int CN = 8192;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [9:0]       base_adr;
    logic [10:0]      len;
    logic [1:0]       busy, done, rd, m_valid, m_ready, m_last;
    logic [1:0][9:0]  adr;
    logic [1:0][7:0]  dat, m_data;

    logic [7:0] mem [MD];
    logic [7:0] ram0_q, ram1_a, ram1_b;

    int n_vec = 0, n_err = 0, cyc = 0, rdy_pct = 100;

    // Reference model: per-DUT queue of words still owed downstream, plus read bookkeeping.
    int exp_d [2][QN];
    bit exp_l [2][QN];
    int qh [2], qt [2], rd_left [2], rd_adr [2], issued [2], popped [2];
    bit done_pend [2], prev_hold [2], prev_l [2];
    int prev_d [2];
    int cap_d [2][CN];
    bit cap_l [2][CN];
    int cap_c [2][CN];
    int cap_n [2], done_cyc [2], zl_cyc [2], last_hs [2], cb [2];

    ram_stream_reader #(.READ_REGISTERED(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .base_adr(base_adr), .len(len),
        .busy(busy[0]), .done(done[0]), .rd(rd[0]), .adr_r(adr[0]), .dat_r(dat[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]), .m_last(m_last[0])
    );

    ram_stream_reader #(.READ_REGISTERED(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .base_adr(base_adr), .len(len),
        .busy(busy[1]), .done(done[1]), .rd(rd[1]), .adr_r(adr[1]), .dat_r(dat[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]), .m_last(m_last[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial for (int i = 0; i < MD; i++) mem[i] = 8'(i);

    // RAM models: one-cycle read, and one-cycle read plus output register.
    always @(posedge clk) begin
        if (rd[0]) ram0_q <= mem[adr[0]];
        if (rd[1]) ram1_a <= mem[adr[1]];
        ram1_b <= ram1_a;
    end
    assign dat[0] = ram0_q;
    assign dat[1] = ram1_b;

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) m_ready[k] = (int'($urandom_range(99)) < rdy_pct);
    end

    task automatic chk(input int k, input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL dut%0d %s: got %0d expected %0d (cycle %0d)", k, nm, act, exp, cyc);
        end
    endtask

    // Compare process: every cycle, every DUT output against the model.
    always @(negedge clk) begin
        int depth, hi;
        cyc = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                chk(k, "rst_busy",    int'(busy[k]), 0);
                chk(k, "rst_done",    int'(done[k]), 0);
                chk(k, "rst_rd",      int'(rd[k]), 0);
                chk(k, "rst_adr",     int'(adr[k]), 0);
                chk(k, "rst_m_valid", int'(m_valid[k]), 0);
                chk(k, "rst_m_last",  int'(m_last[k]), 0);
                chk(k, "rst_m_data",  int'(m_data[k]), 0);
                qh[k] = 0; qt[k] = 0; rd_left[k] = 0; issued[k] = 0; popped[k] = 0;
                done_pend[k] = 0; prev_hold[k] = 0;
            end else begin
                depth = qt[k] - qh[k];
                chk(k, "busy", int'(busy[k]), int'(depth != 0));
                chk(k, "done", int'(done[k]), int'(done_pend[k]));
                if (done[k]) done_cyc[k] = cyc;
                done_pend[k] = 0;
                if (rd[k]) begin
                    chk(k, "rd_credit", int'((issued[k] - popped[k]) < FD), 1);
                    chk(k, "rd_wanted", int'(rd_left[k] > 0), 1);
                    chk(k, "rd_adr", int'(adr[k]), rd_adr[k]);
                    issued[k]++;
                    if (rd_left[k] > 0) rd_left[k]--;
                    rd_adr[k] = (rd_adr[k] + 1) % MD;
                end
                if (prev_hold[k]) begin
                    chk(k, "hold_valid", int'(m_valid[k]), 1);
                    chk(k, "hold_data", int'(m_data[k]), prev_d[k]);
                    chk(k, "hold_last", int'(m_last[k]), int'(prev_l[k]));
                end
                if (m_valid[k] && depth == 0) begin
                    chk(k, "stray_valid", int'(m_valid[k]), 0);
                end else if (m_valid[k] && m_ready[k]) begin
                    hi = qh[k] % QN;
                    chk(k, "m_data", int'(m_data[k]), exp_d[k][hi]);
                    chk(k, "m_last", int'(m_last[k]), int'(exp_l[k][hi]));
                    if (cap_n[k] < CN) begin
                        cap_d[k][cap_n[k]] = int'(m_data[k]);
                        cap_l[k][cap_n[k]] = m_last[k];
                        cap_c[k][cap_n[k]] = cyc;
                        cap_n[k]++;
                    end
                    if (exp_l[k][hi]) begin
                        done_pend[k] = 1;
                        last_hs[k] = cyc;
                    end
                    qh[k]++;
                    popped[k]++;
                end
                prev_hold[k] = m_valid[k] && !m_ready[k];
                prev_d[k] = int'(m_data[k]);
                prev_l[k] = m_last[k];
                if (start && depth == 0) begin
                    if (len == 0) begin
                        done_pend[k] = 1;
                        zl_cyc[k] = cyc;
                    end else begin
                        for (int i = 0; i < int'(len); i++) begin
                            exp_d[k][qt[k] % QN] = ((int'(base_adr) + i) % MD) % 256;
                            exp_l[k][qt[k] % QN] = (i == int'(len) - 1);
                            qt[k]++;
                        end
                        rd_left[k] = int'(len);
                        rd_adr[k] = int'(base_adr);
                    end
                end
            end
        end
    end

    task automatic do_start(input int b, input int l);
        @(posedge clk); #1;
        start = 1'b1; base_adr = 10'(b); len = 11'(l);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        bit ok;
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk); #2;
            if (qt[0] == qh[0] && qt[1] == qh[1] && !done_pend[0] && !done_pend[1] && !start) begin
                ok = 1;
                break;
            end
        end
        chk(0, "idle_timeout", int'(ok), 1);
    endtask

    task automatic snap();
        for (int k = 0; k < 2; k++) cb[k] = cap_n[k];
    endtask

    task automatic chk_words(input int first, input int n);
        for (int k = 0; k < 2; k++) begin
            chk(k, "word_count", cap_n[k] - cb[k], n);
            for (int i = 0; i < n; i++) begin
                chk(k, "word_data", cap_d[k][cb[k] + i], (first + i) % 256);
                chk(k, "word_last", int'(cap_l[k][cb[k] + i]), int'(i == n - 1));
            end
        end
    endtask

    initial begin
        int wrap_exp [8] = '{252, 253, 254, 255, 0, 1, 2, 3};
        int pcts [4] = '{100, 30, 70, 50};
        int d, b, l;
        bit hit;
        rst_n = 1'b1; start = 1'b0; base_adr = '0; len = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Full-rate burst from address 0.
        rdy_pct = 100;
        snap();
        do_start(0, 8);
        wait_idle(2000);
        chk_words(0, 8);
        for (int k = 0; k < 2; k++) begin
            for (int i = 1; i < 8; i++)
                chk(k, "back_to_back", cap_c[k][cb[k] + i] - cap_c[k][cb[k]], i);
            chk(k, "done_after_last", done_cyc[k] - last_hs[k], 1);
        end

        // Address wrap 1023 -> 0.
        snap();
        do_start(1020, 8);
        wait_idle(2000);
        for (int k = 0; k < 2; k++) begin
            chk(k, "wrap_count", cap_n[k] - cb[k], 8);
            for (int i = 0; i < 8; i++) begin
                chk(k, "wrap_data", cap_d[k][cb[k] + i], wrap_exp[i]);
                chk(k, "wrap_last", int'(cap_l[k][cb[k] + i]), int'(i == 7));
            end
        end

        // Sparse backpressure.
        rdy_pct = 30;
        snap();
        do_start(0, 16);
        wait_idle(2000);
        chk_words(0, 16);

        // Zero-length request.
        rdy_pct = 100;
        snap();
        do_start(5, 0);
        wait_idle(100);
        for (int k = 0; k < 2; k++) begin
            chk(k, "zero_len_done", done_cyc[k] - zl_cyc[k], 1);
            chk(k, "zero_len_words", cap_n[k] - cb[k], 0);
        end

        // Reset in the middle of a transfer, then a clean short transfer.
        snap();
        do_start(0, 40);
        hit = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #2;
            if (cap_n[1] - cb[1] >= 5) begin
                hit = 1;
                break;
            end
        end
        chk(1, "reach_5_words", int'(hit), 1);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;
        snap();
        do_start(100, 3);
        wait_idle(2000);
        chk_words(100, 3);

        // Start held high across transfers: back-to-back transfers, never overlapping.
        rdy_pct = 70;
        snap();
        @(posedge clk); #1;
        start = 1'b1; base_adr = 10'd200; len = 11'd4;
        repeat (40) @(posedge clk);
        #1 start = 1'b0;
        wait_idle(2000);
        for (int k = 0; k < 2; k++) begin
            d = cap_n[k] - cb[k];
            chk(k, "held_start_xfers", int'((d % 4 == 0) && (d >= 8)), 1);
        end

        // Randomized transfers.
        for (int n = 0; n < 40; n++) begin
            rdy_pct = pcts[$urandom_range(3)];
            b = int'($urandom_range(MD - 1));
            l = (int'($urandom_range(9)) == 0) ? 0 : int'($urandom_range(40, 1));
            do_start(b, l);
            wait_idle(2000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
